uart_seq_detect: RTL
====================

# uart_seq_detect

Multi-byte pattern detector on a serial UART line; the parametrised successor to the single-byte UART compare detector. Instantiates the existing `uart_rx` receiver, keeps a sliding window of the last `SEQ_LEN` received bytes, and pulses `match` when the window equals a runtime-programmable pattern. Adds inter-byte gap timeout, overlapping-match support, a saturating match counter and optional per-bit masking. Sits between the serial input pin and the brute-force control logic that consumes match events.

## Interface
- `SEQ_LEN`, 4, pattern length in bytes (1..16)
- `GAP_CYCLES`, 1000000, clk cycles without a byte before a partial window is discarded; 0 disables timeout
- `CNT_W`, 16, width of `match_count`

- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset, asynchronous, active-high
- `din`  in  1  serial UART line, to `uart_rx`
- `en`  in  1  detector enable
- `pattern`  in  8*SEQ_LEN  target sequence; byte i at `[8*i+7:8*i]`, byte 0 = first received
- `mask`  in  8*SEQ_LEN  per-bit compare enable, 1 = compare (present only with `UART_SEQ_MASK_EN`)
- `clr_count`  in  1  synchronous clear of `match_count`
- `match`  out  1  one-cycle pulse on a full-window match
- `byte_strobe`  out  1  one-cycle pulse per accepted byte
- `last_byte`  out  8  most recently accepted byte
- `fill_level`  out  $clog2(SEQ_LEN+1)  valid bytes in window, 0..SEQ_LEN
- `match_count`  out  CNT_W  saturating count of matches

## Operation
- Reset: all outputs 0, window 0, gap counter 0, state IDLE. `uart_rx` `rst` driven from `rst`.
- Accepted byte: `uart_rx` valid pulse while `en`=1. Window shifts: existing bytes move one slot toward index 0, new byte enters slot `SEQ_LEN-1`. `fill_level` increments, saturating at `SEQ_LEN`.
- States (derived from fill): IDLE (fill 0), FILL (0 < fill < SEQ_LEN), ARMED (fill = SEQ_LEN). IDLE→FILL on first byte; FILL→ARMED when fill reaches SEQ_LEN; any→IDLE on timeout or `en`=0.
- Compare: computed on the post-shift window; `match`=1 iff ARMED after the shift and every compared bit equals `pattern`. Window is not cleared on match, so overlapping matches are detected (e.g. "AAA" within "AAAA" matches twice).
- Gap timer: counts while fill > 0, cleared on each accepted byte. On reaching `GAP_CYCLES` with no byte: fill → 0, state IDLE. Byte and expiry in same cycle: byte wins, counter clears, no flush.
- `en`=0: bytes ignored, fill → 0, gap counter held 0, `match`/`byte_strobe` 0. `match_count` retained.
- `match_count` increments on each `match`, saturates at 2^CNT_W−1. `clr_count` and `match` same cycle: result 0.
- `pattern`/`mask` are not latched; must be stable while `en`=1. Change requires `en` low for ≥1 cycle.

## Timing
- `uart_rx` valid at cycle N → window, `fill_level`, `last_byte` updated and `match`, `byte_strobe` high in cycle N+1 (one registered stage, same latency as the single-byte detector).
- `match_count` reflects the match in cycle N+2.
- Back-to-back valid pulses are each accepted; no throughput limit beyond `uart_rx`.
- `rst` asserted mid-frame: immediate clear; partial `uart_rx` frame discarded.

## Configuration
- `UART_SEQ_MASK_EN` defined: `mask` port present; bits with mask 0 are don't-care. An all-zero mask matches any full window.
- Not defined: no `mask` port; all 8*SEQ_LEN bits compared.

## Structure
- Package `uart_seq_pkg`: `BYTE_W`=8, state enum `IDLE/FILL/ARMED`, function for fill width ($clog2(SEQ_LEN+1)).
- Sub-module: existing `uart_rx`, instantiated once; window, compare, gap timer and counter in this module.

## Test plan
- SEQ_LEN=4, pattern=32'h44434241, send "ABCD" → one `match` one cycle after the 'D' valid pulse, `match_count`=1.
- Send "ABCABCD" → exactly one match after final 'D'; `fill_level` saturates at 4 after the fourth byte.
- Pattern 32'h41414141, send eight 0x41 → five matches, `match_count`=5.
- GAP_CYCLES=100: send "AB", idle 100 cycles, send "CD" → `fill_level` returns to 0, no match; repeat with 99-cycle gap → match.
- With `UART_SEQ_MASK_EN`, mask=32'hFFFFFF00, send "XBCD" → match; `clr_count` asserted on match cycle → `match_count`=0.
- Assert `rst` mid-'C' frame and `en`=0 during "ABCD" → all outputs 0, no match, `match_count` unchanged under `en`=0.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// Shared types and helpers for the UART multi-byte sequence detector.
package uart_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ARMED
  } seq_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic int fill_w(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

endpackage

// File: rtl/uart_seq_detect_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling, one-cycle valid pulse.
// CLKS_PER_BIT must be at least 2.
module uart_rx
  import uart_seq_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data,
  output logic       valid
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  rx_state_e     st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      st    <= RX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      valid <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          if (!s2) begin
            st  <= RX_START;
            cnt <= '0;
          end
        end
        RX_START: begin
          // re-check the start bit at its midpoint to reject glitches
          if (cnt == HALF_END) begin
            cnt <= '0;
            idx <= '0;
            st  <= s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shreg <= {s2, shreg[7:1]};
            if (idx == 3'd7) st <= RX_STOP;
            else idx <= idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            st    <= RX_IDLE;
            valid <= s2;
            data  <= shreg;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_seq_detect.sv
// Sliding-window multi-byte pattern detector behind uart_rx.
// Define UART_SEQ_MASK_EN to add the per-bit compare mask port.
module uart_seq_detect
  import uart_seq_pkg::*;
#(
  parameter int SEQ_LEN      = 4,
  parameter int GAP_CYCLES   = 1000000,
  parameter int CNT_W        = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din,
  input  logic                          en,
  input  logic [BYTE_W*SEQ_LEN-1:0]     pattern,
`ifdef UART_SEQ_MASK_EN
  input  logic [BYTE_W*SEQ_LEN-1:0]     mask,
`endif
  input  logic                          clr_count,
  output logic                          match,
  output logic                          byte_strobe,
  output logic [BYTE_W-1:0]             last_byte,
  output logic [fill_w(SEQ_LEN)-1:0]    fill_level,
  output logic [CNT_W-1:0]              match_count
);

  localparam int FW = fill_w(SEQ_LEN);
  localparam int WIN_W = BYTE_W * SEQ_LEN;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);
  localparam logic [FW-1:0] FULL = FW'(SEQ_LEN);

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic [WIN_W-1:0]  window;
  logic [WIN_W-1:0]  win_next;
  logic [WIN_W-1:0]  cmp_mask;
  logic [FW-1:0]     fill_next;
  logic [GW-1:0]     gap_cnt;
  logic              hit;
  logic              full_next;
  seq_state_e        state;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .data (rx_data),
    .valid(rx_valid)
  );

`ifdef UART_SEQ_MASK_EN
  assign cmp_mask = mask;
`else
  assign cmp_mask = '1;
`endif

  // oldest byte sits in slot 0, newest enters the top slot
  if (SEQ_LEN == 1) begin : g_one
    assign win_next = rx_data;
  end else begin : g_multi
    assign win_next = {rx_data, window[WIN_W-1:BYTE_W]};
  end

  assign fill_next = (fill_level == FULL) ? FULL : fill_level + FW'(1);
  assign full_next = (fill_next == FULL);
  assign hit = (((win_next ^ pattern) & cmp_mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      window      <= '0;
      gap_cnt     <= '0;
      fill_level  <= '0;
      last_byte   <= '0;
      match       <= 1'b0;
      byte_strobe <= 1'b0;
      match_count <= '0;
    end else begin
      match       <= 1'b0;
      byte_strobe <= 1'b0;
      if (!en) begin
        state      <= IDLE;
        fill_level <= '0;
        gap_cnt    <= '0;
      end else if (rx_valid) begin
        window      <= win_next;
        last_byte   <= rx_data;
        byte_strobe <= 1'b1;
        fill_level  <= fill_next;
        gap_cnt     <= '0;
        state       <= full_next ? ARMED : FILL;
        match       <= full_next && hit;
      end else if (state != IDLE && GAP_CYCLES != 0) begin
        if (gap_cnt == GAP_LAST) begin
          state      <= IDLE;
          fill_level <= '0;
          gap_cnt    <= '0;
        end else begin
          gap_cnt <= gap_cnt + GW'(1);
        end
      end

      // clear wins over a coincident match
      if (clr_count) begin
        match_count <= '0;
      end else if (match && match_count != '1) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule
